// File: rtl/id_alu_issue.sv
// id_alu_issue: RV64I decode/issue stage feeding the EX ALU through a valid/ready ID/EX register.
// Define ISSUE_ANDN_EN to decode OP funct7=0100000 funct3=111 as ANDN; otherwise it is illegal.
module id_alu_issue #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 12,
  parameter int BJ_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [ALU_W-1:0] alu_info,
  output logic             is_word_opt,
  output logic [BJ_W-1:0]  bj_sel,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc,
  output logic [4:0]       rd,
  output logic             rd_wen,
  output logic             illegal
);
  localparam logic [6:0] OPC_IMM = 7'b0010011, OPC_IMM32 = 7'b0011011, OPC_OP = 7'b0110011,
                         OPC_OP32 = 7'b0111011, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3, A_XOR = 4'd4,
                         A_OR = 4'd5, A_AND = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9,
                         A_ANDN = 4'd10, A_WRI = 4'd11;
`ifdef ISSUE_ANDN_EN
  localparam bit ANDN_EN = 1'b1;
`else
  localparam bit ANDN_EN = 1'b0;
`endif
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic [XLEN-1:0]  op1, op2, imm, pc;
    logic [ALU_W-1:0] alu;
    logic             word;
    logic [BJ_W-1:0]  bj;
    logic [4:0]       rd;
    logic             wen, ill;
  } ent_t;
  state_t state_q, state_d;
  ent_t ent_q, ent_d, dec;
  logic [6:0] opc, f7;
  logic [2:0] f3, bi;
  logic [3:0] ai, ai_f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic ill, bj_en, use1, use2, alt, hazard, load;
  assign opc = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  assign alt = f7 == 7'b0100000;
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  // funct3 mapping shared by register and immediate ALU forms; bit 30 picks arithmetic right shift
  assign ai_f3 = f3 == 3'b001 ? A_SLL : f3 == 3'b010 ? A_SLT : f3 == 3'b011 ? A_SLTU :
                 f3 == 3'b100 ? A_XOR : f3 == 3'b101 ? (in_inst[30] ? A_SRA : A_SRL) :
                 f3 == 3'b110 ? A_OR : f3 == 3'b111 ? A_AND : A_ADD;
  always_comb begin
    dec = '0;
    ill = 1'b0;
    ai = A_ADD;
    bi = 3'd0;
    bj_en = 1'b0;
    use1 = 1'b0;
    use2 = 1'b0;
    dec.pc = in_pc;
    dec.op1 = rs1_data;
    dec.op2 = rs2_data;
    case (opc)
      OPC_IMM, OPC_IMM32: begin
        use1 = 1'b1;
        dec.word = opc == OPC_IMM32;
        dec.op2 = imm_i;
        dec.imm = imm_i;
        ai = ai_f3;
        if (f3 == 3'b001)
          ill = dec.word ? f7 != 7'b0 : in_inst[31:26] != 6'b0;
        else if (f3 == 3'b101)
          ill = dec.word ? f7 != 7'b0 && !alt : in_inst[31:26] != 6'b0 && in_inst[31:26] != 6'b010000;
      end
      OPC_OP, OPC_OP32: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.word = opc == OPC_OP32;
        ai = alt && f3 == 3'b000 ? A_SUB : alt && f3 == 3'b111 ? A_ANDN : ai_f3;
        ill = !(f7 == 7'b0 || (alt && (f3 == 3'b000 || f3 == 3'b101 || (ANDN_EN && f3 == 3'b111))));
      end
      OPC_LUI: begin
        ai = A_WRI;
        dec.op1 = '0;
        dec.op2 = imm_u;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
        dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'(4);
        dec.imm = imm_j;
        bj_en = 1'b1;
        bi = 3'd7;
      end
      OPC_JALR: begin
        use1 = 1'b1;
        dec.op1 = in_pc;
        dec.op2 = XLEN'(4);
        dec.imm = imm_i;
        bj_en = 1'b1;
        bi = 3'd6;
        ill = f3 != 3'b000;
      end
      OPC_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.imm = imm_b;
        bj_en = 1'b1;
        bi = f3[2] ? f3 - 3'd2 : f3;
        ai = f3[2] ? (f3[1] ? A_SLTU : A_SLT) : A_XOR;
        ill = f3[2:1] == 2'b01;
      end
      default: ill = 1'b1;
    endcase
    // word right shifts see only the low half of rs1; word shift amounts are 5 bits
    if (dec.word && (ai == A_SRL || ai == A_SRA)) dec.op1 = {{(XLEN-32){1'b0}}, rs1_data[31:0]};
    if (dec.word && (ai == A_SLL || ai == A_SRL || ai == A_SRA)) dec.op2[5] = 1'b0;
    ill = ill || (dec.word && !(ai inside {A_ADD, A_SUB, A_SLL, A_SRL, A_SRA}));
    dec.ill = ill;
    dec.word = dec.word && !ill;
    dec.alu = ill ? '0 : ALU_W'(1) << ai;
    dec.bj = ill || !bj_en ? '0 : BJ_W'(1) << bi;
    dec.rd = ill || opc == OPC_BRANCH ? 5'd0 : in_inst[11:7];
    dec.wen = dec.rd != 5'd0;
  end
  assign hazard = ex_is_load && ex_rd != 5'd0 &&
                  ((use1 && ex_rd == rs1_addr) || (use2 && ex_rd == rs2_addr));
  assign in_ready = (state_q == EMPTY || out_ready) && !hazard;
  assign load = in_valid && in_ready && !flush;
  always_comb begin
    state_d = flush ? EMPTY : load ? FULL : out_ready ? EMPTY : state_q;
    ent_d = load ? dec : ent_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      ent_q <= '0;
    end else begin
      state_q <= state_d;
      ent_q <= ent_d;
    end
  assign out_valid = state_q == FULL;
  assign op1 = ent_q.op1;
  assign op2 = ent_q.op2;
  assign alu_info = ent_q.alu;
  assign is_word_opt = ent_q.word;
  assign bj_sel = ent_q.bj;
  assign imm = ent_q.imm;
  assign pc = ent_q.pc;
  assign rd = ent_q.rd;
  assign rd_wen = ent_q.wen;
  assign illegal = ent_q.ill;
endmodule

// File: tb/tb_id_alu_issue.sv
// tb_id_alu_issue: directed vectors for id_alu_issue; expected issue entries go to a scoreboard queue.
module tb_id_alu_issue;
  logic clk, rst_n, in_valid, in_ready, ex_is_load, flush, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, rs1_data, rs2_data, op1, op2, imm, pc;
  logic [4:0] rs1_addr, rs2_addr, ex_rd, rd;
  logic [11:0] alu_info;
  logic [7:0] bj_sel;
  logic is_word_opt, rd_wen, illegal;
  int tests = 0, fails = 0;
  typedef struct {
    logic [63:0] op1, op2, imm, pc;
    logic [11:0] alu;
    logic [7:0] bj;
    logic w;
    logic [4:0] rd;
    logic wen, ill;
    bit ops;
  } exp_t;
  exp_t q[$];
  exp_t me;
  id_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .alu_info(alu_info),
    .is_word_opt(is_word_opt), .bj_sel(bj_sel), .imm(imm), .pc(pc), .rd(rd), .rd_wen(rd_wen),
    .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t mk(logic [63:0] o1, o2, im, p, logic [11:0] a, logic [7:0] b,
                              logic w, logic [4:0] r, logic we, il, bit ops);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.imm = im; e.pc = p; e.alu = a; e.bj = b;
    e.w = w; e.rd = r; e.wen = we; e.ill = il; e.ops = ops;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic send(input logic [31:0] inst, input logic [63:0] p, r1, r2, input exp_t e);
    in_valid = 1'b1; in_inst = inst; in_pc = p; rs1_data = r1; rs2_data = r2;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL send_timeout: inst %h never accepted", inst);
    in_valid = 1'b0;
  endtask
  // scoreboard monitor: every accepted transfer is checked against the oldest expectation
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: pc=%h alu=%h with empty scoreboard", pc, alu_info);
      end else begin
        me = q.pop_front();
        if (alu_info !== me.alu || bj_sel !== me.bj || is_word_opt !== me.w || rd !== me.rd ||
            rd_wen !== me.wen || illegal !== me.ill ||
            (me.ops && (op1 !== me.op1 || op2 !== me.op2 || imm !== me.imm || pc !== me.pc))) begin
          fails++;
          $display("FAIL issue: got op1=%h op2=%h imm=%h pc=%h alu=%h bj=%h w=%b rd=%0d wen=%b ill=%b want op1=%h op2=%h imm=%h pc=%h alu=%h bj=%h w=%b rd=%0d wen=%b ill=%b",
                   op1, op2, imm, pc, alu_info, bj_sel, is_word_opt, rd, rd_wen, illegal,
                   me.op1, me.op2, me.imm, me.pc, me.alu, me.bj, me.w, me.rd, me.wen, me.ill);
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = '0; rs1_data = '0; rs2_data = '0;
    ex_rd = '0; ex_is_load = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, |op1, |op2, |alu_info, is_word_opt, |bj_sel, |imm, |pc, |rd, rd_wen, illegal}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    send(32'h00500093, 64'h1000, 64'h0, 64'h0, mk(64'h0, 64'h5, 64'h5, 64'h1000, 12'h001, 8'h0, 0, 5'd1, 1, 0, 1));
    chk("addi_valid_next", out_valid, 1);
    send(32'h123453B7, 64'h1004, 64'h0, 64'h0, mk(64'h0, 64'h12345000, 64'h12345000, 64'h1004, 12'h800, 8'h0, 0, 5'd7, 1, 0, 1));
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h80000417; in_pc = 64'h2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, in_ready, alu_info, op2, pc}, {1'b1, 1'b0, 12'h800, 64'h12345000, 64'h1004});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h80000417, 64'h2000, 64'h0, 64'h0, mk(64'h2000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'h2000, 12'h001, 8'h0, 0, 5'd8, 1, 0, 1));
    chk("auipc_loaded_after_stall", {out_valid, pc}, {1'b1, 64'h2000});
    send(32'h405251BB, 64'h2004, 64'hFFFF_FFFF_8000_0000, 64'd63, mk(64'h0000_0000_8000_0000, 64'd31, 64'h0, 64'h2004, 12'h200, 8'h0, 1, 5'd3, 1, 0, 1));
    ex_is_load = 1'b1; ex_rd = 5'd2;
    in_valid = 1'b1; in_inst = 32'h001101B3; in_pc = 64'h2008; rs1_data = 64'd10; rs2_data = 64'd20;
    #1 chk("rs_addr", {rs1_addr, rs2_addr}, {5'd2, 5'd1});
    @(negedge clk);
    chk("hazard_not_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("hazard_bubble", out_valid, 0);
    ex_is_load = 1'b0;
    send(32'h001101B3, 64'h2008, 64'd10, 64'd20, mk(64'd10, 64'd20, 64'h0, 64'h2008, 12'h001, 8'h0, 0, 5'd3, 1, 0, 1));
    ex_is_load = 1'b1; ex_rd = 5'd5; in_inst = 32'h00500093;
    @(negedge clk);
    chk("no_hazard_unused_rs2", in_ready, 1);
    @(posedge clk); #1;
    send(32'h00500093, 64'h2010, 64'h0, 64'h0, mk(64'h0, 64'h5, 64'h5, 64'h2010, 12'h001, 8'h0, 0, 5'd1, 1, 0, 1));
    ex_is_load = 1'b0;
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_inst = 32'h010000EF; in_pc = 64'h3000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(q.pop_back());
    chk("flush_clears_and_drops_incoming", out_valid, 0);
    out_ready = 1'b1;
    send(32'hFE20ECE3, 64'h100, 64'd1, 64'd2, mk(64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 12'h008, 8'h10, 0, 5'd0, 0, 0, 1));
    send(32'h010000EF, 64'h3000, 64'h0, 64'h0, mk(64'h3000, 64'd4, 64'd16, 64'h3000, 12'h001, 8'h80, 0, 5'd1, 1, 0, 1));
    send(32'h00008067, 64'h3010, 64'h4000, 64'h0, mk(64'h3010, 64'd4, 64'h0, 64'h3010, 12'h001, 8'h40, 0, 5'd0, 0, 0, 1));
    send(32'h02819113, 64'h3014, 64'h11, 64'h0, mk(64'h11, 64'd40, 64'd40, 64'h3014, 12'h080, 8'h0, 0, 5'd2, 1, 0, 1));
    send(32'h8001D113, 64'h3018, 64'h11, 64'h0, mk(64'h0, 64'h0, 64'h0, 64'h0, 12'h000, 8'h0, 0, 5'd0, 0, 1, 0));
    send(32'h403100BB, 64'h301C, 64'hFFFF_FFFF_0000_0001, 64'd1, mk(64'hFFFF_FFFF_0000_0001, 64'd1, 64'h0, 64'h301C, 12'h002, 8'h0, 1, 5'd1, 1, 0, 1));
    send(32'h003110BB, 64'h3020, 64'd5, 64'h3F, mk(64'd5, 64'h1F, 64'h0, 64'h3020, 12'h080, 8'h0, 1, 5'd1, 1, 0, 1));
    send(32'h003120BB, 64'h3024, 64'd5, 64'd6, mk(64'h0, 64'h0, 64'h0, 64'h0, 12'h000, 8'h0, 0, 5'd0, 0, 1, 0));
`ifdef ISSUE_ANDN_EN
    send(32'h407372B3, 64'h3028, 64'hF0, 64'h30, mk(64'hF0, 64'h30, 64'h0, 64'h3028, 12'h400, 8'h0, 0, 5'd5, 1, 0, 1));
`else
    send(32'h407372B3, 64'h3028, 64'hF0, 64'h30, mk(64'h0, 64'h0, 64'h0, 64'h0, 12'h000, 8'h0, 0, 5'd0, 0, 1, 0));
`endif
    send(32'h00000013, 64'h302C, 64'h0, 64'h0, mk(64'h0, 64'h0, 64'h0, 64'h302C, 12'h001, 8'h0, 0, 5'd0, 0, 0, 1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00500093, 64'h5000, 64'h0, 64'h0, mk(64'h0, 64'h5, 64'h5, 64'h5000, 12'h001, 8'h0, 0, 5'd1, 1, 0, 1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drops_entry", {out_valid, |pc}, '0);
    void'(q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
